freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/lab7_pkg.sv | 30 +++
 rtl/bin2bcd.sv | 76 +++++++
 rtl/freq_meter.sv | 101 ++++++++++
 tb/tb_freq_meter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/lab7_pkg.sv
// Shared constants, converter state encoding and the BCD digit adjust helper
// used by the frequency meter and its binary-to-BCD converter.
package lab7_pkg;

  localparam int CNT_W      = 27;
  localparam int SAT_MAX    = 99_999_999;
  localparam int BCD_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Double-dabble correction: every BCD digit of 5 or more gets 3 added so the
  // following left shift carries correctly into the next digit.
  function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] bcd);
    logic [4*BCD_DIGITS-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        res[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd.sv
// Sequential double-dabble converter: one iteration per clock, BIN_W
// iterations per conversion, result published in a single DONE cycle.
// A new start in any state restarts the conversion with the new value.
module bin2bcd #(
  parameter int BIN_W = lab7_pkg::CNT_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [BIN_W-1:0]                  bin,
  output logic                              busy,
  output logic                              done,
  output logic [4*lab7_pkg::BCD_DIGITS-1:0] bcd
);
  import lab7_pkg::*;

  localparam int BCD_W = 4 * BCD_DIGITS;
  localparam int IT_W  = $clog2(BIN_W + 1);
  localparam logic [IT_W-1:0] LAST_IT = IT_W'(BIN_W - 1);

  conv_state_t              state_r;
  logic [BCD_W+BIN_W-1:0]   sr_r;
  logic [BCD_W+BIN_W-1:0]   sr_step_s;
  logic [BCD_W-1:0]         adj_s;
  logic [IT_W-1:0]          it_r;

  // One double-dabble iteration: correct the BCD digits, then shift left by one
  always_comb begin
    adj_s     = bcd_adjust(sr_r[BCD_W+BIN_W-1:BIN_W]);
    sr_step_s = {adj_s[BCD_W-2:0], sr_r[BIN_W-1:0], 1'b0};
  end

  // Converter FSM with registered busy/done/bcd; start always wins (abort + reload)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
      sr_r    <= '0;
      it_r    <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        state_r <= ST_SHIFT;
        sr_r    <= {{BCD_W{1'b0}}, bin};
        it_r    <= '0;
        busy    <= 1'b1;
      end else begin
        case (state_r)
          ST_IDLE: begin
            busy <= 1'b0;
          end
          ST_SHIFT: begin
            sr_r <= sr_step_s;
            it_r <= it_r + 1'b1;
            if (it_r == LAST_IT) begin
              state_r <= ST_DONE;
              done    <= 1'b1;
              bcd     <= sr_step_s[BCD_W+BIN_W-1:BIN_W];
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
          default: begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/freq_meter.sv
// Frequency meter: synchronizes sig_in, counts its rising edges over each
// 1 Hz window, latches the count (saturated) on tick_1s and converts it to BCD.
module freq_meter #(
  parameter int CNT_W   = lab7_pkg::CNT_W,
  parameter int SAT_MAX = lab7_pkg::SAT_MAX
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_1s,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_bin,
  output logic [31:0]      freq_bcd,
  output logic             ovf,
  output logic             valid,
  output logic             busy
);
  import lab7_pkg::*;

  localparam logic [CNT_W-1:0] SAT_V = CNT_W'(SAT_MAX);

  logic                    sync1_r, sync2_r, sync3_r;
  logic                    edge_s;
  logic [CNT_W-1:0]        cnt_r, cnt_next_s;
  logic                    sat_r, sat_next_s;
  logic                    armed_r;
  logic                    ovf_pend_r, ovf_r;
  logic                    start_s;
  logic [4*BCD_DIGITS-1:0] bcd_s;

  // Two-flop synchronizer plus one history flop for rising-edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= sig_in;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  assign edge_s  = sync2_r & ~sync3_r;
  assign start_s = tick_1s & armed_r;

  // Count including this cycle's edge, held at the saturation value
  always_comb begin
    if (edge_s && (cnt_r != SAT_V)) begin
      cnt_next_s = cnt_r + 1'b1;
    end else begin
      cnt_next_s = cnt_r;
    end
    sat_next_s = sat_r | (cnt_next_s == SAT_V);
  end

  // Window counter, arming and the end-of-window latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r      <= '0;
      sat_r      <= 1'b0;
      armed_r    <= 1'b0;
      freq_bin   <= '0;
      ovf_pend_r <= 1'b0;
    end else if (tick_1s) begin
      cnt_r   <= '0;
      sat_r   <= 1'b0;
      armed_r <= 1'b1;
      if (armed_r) begin
        freq_bin   <= cnt_next_s;
        ovf_pend_r <= sat_next_s;
      end
    end else begin
      cnt_r <= cnt_next_s;
      sat_r <= sat_next_s;
    end
  end

  // Published overflow flag, refreshed from the pending value on each valid pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_r <= 1'b0;
    end else if (valid) begin
      ovf_r <= ovf_pend_r;
    end
  end

  // During the DONE cycle the pending flag is shown so ovf changes with freq_bcd
  assign ovf      = valid ? ovf_pend_r : ovf_r;
  assign freq_bcd = bcd_s;

  bin2bcd #(.BIN_W(CNT_W)) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start_s),
    .bin   (cnt_next_s),
    .busy  (busy),
    .done  (valid),
    .bcd   (bcd_s)
  );

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter: a default instance and one with SAT_MAX=999
// share every input; expected values are hand-computed per scenario.
module tb_freq_meter;

  logic        clk;
  logic        rst;
  logic        tick_1s;
  logic        sig_in;
  logic [26:0] freq_bin, freq_bin_s;
  logic [31:0] freq_bcd, freq_bcd_s;
  logic        ovf, ovf_s, valid, valid_s, busy, busy_s;

  int n_total = 0;
  int n_bad   = 0;
  int half    = 5;
  int ph      = 0;
  logic man_sig = 1'b0;
  int since   = 0;
  int nvalid  = 0;
  int nvalid_s = 0;
  int vat     = 0;
  int n0      = 0;
  logic [31:0] cap_bcd = 32'd0, cap_bcd_s = 32'd0;
  logic        cap_ovf = 1'b0, cap_ovf_s = 1'b0;

  freq_meter dut (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .sig_in(sig_in),
    .freq_bin(freq_bin), .freq_bcd(freq_bcd), .ovf(ovf), .valid(valid), .busy(busy)
  );

  freq_meter #(.SAT_MAX(999)) dut_s (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .sig_in(sig_in),
    .freq_bin(freq_bin_s), .freq_bcd(freq_bcd_s), .ovf(ovf_s), .valid(valid_s), .busy(busy_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // One clock: drive inputs, wait for the edge, sample 1 ns later
  task automatic cyc(input logic tk);
    tick_1s = tk;
    if (half == 0) sig_in = man_sig;
    else           sig_in = ((ph / half) % 2) == 1;
    ph++;
    @(posedge clk);
    #1;
    if (tk) since = 1;
    else    since++;
    if (valid === 1'b1) begin
      nvalid++;
      vat     = since;
      cap_bcd = freq_bcd;
      cap_ovf = ovf;
    end
    if (valid_s === 1'b1) begin
      nvalid_s++;
      cap_bcd_s = freq_bcd_s;
      cap_ovf_s = ovf_s;
    end
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  initial begin
    tick_1s = 1'b0;
    sig_in  = 1'b0;
    rst     = 1'b1;
    #1 rst  = 1'b0;
    #2;
    check("rst_bin",   freq_bin, 32'd0);
    check("rst_bcd",   freq_bcd, 32'd0);
    check("rst_ovf",   ovf,      32'd0);
    check("rst_valid", valid,    32'd0);
    check("rst_busy",  busy,     32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    // Scenario 1: period 10, 1000-clk windows
    half = 5; ph = 0;
    gap(300);
    cyc(1'b1);
    check("s1_arm_bin", freq_bin, 32'd0);
    n0 = nvalid;
    gap(40);
    check("s1_arm_novalid", nvalid - n0, 32'd0);
    check("s1_arm_busy", busy, 32'd0);
    gap(959);
    cyc(1'b1);
    check("s1_bin", freq_bin, 32'd100);
    check("s1_busy", busy, 32'd1);
    n0 = nvalid;
    gap(40);
    check("s1_nvalid", nvalid - n0, 32'd1);
    check("s1_latency", vat, 32'd28);
    check("s1_bcd", cap_bcd, 32'h0000_0100);
    check("s1_ovf", cap_ovf, 32'd0);
    check("s1_hold", freq_bcd, 32'h0000_0100);
    check("s1_idle", busy, 32'd0);

    // Scenario 2: toggle every clk, 4000-clk window, saturating instance
    half = 1;
    gap(59);
    cyc(1'b1);
    gap(3999);
    cyc(1'b1);
    check("s2_bin_sat",  freq_bin_s, 32'd999);
    check("s2_bin_full", freq_bin,   32'd2000);
    n0 = nvalid_s;
    gap(40);
    check("s2_nvalid", nvalid_s - n0, 32'd1);
    check("s2_bcd_sat", cap_bcd_s, 32'h0000_0999);
    check("s2_ovf_sat", cap_ovf_s, 32'd1);
    check("s2_bcd_full", cap_bcd, 32'h0000_2000);
    check("s2_ovf_full", cap_ovf, 32'd0);
    check("s2_ovf_hold", ovf_s, 32'd1);
    check("s2_idle_sat", busy_s, 32'd0);
    half = 5;
    gap(59);
    cyc(1'b1);
    gap(999);
    cyc(1'b1);
    check("s2_next_bin", freq_bin_s, 32'd100);
    gap(40);
    check("s2_next_ovf", cap_ovf_s, 32'd0);
    check("s2_next_bcd", cap_bcd_s, 32'h0000_0100);

    // Scenario 3: 50 edges before the arming tick are discarded
    rst = 1'b0;
    gap(3);
    rst = 1'b1;
    half = 5; ph = 0;
    gap(500);
    n0 = nvalid;
    cyc(1'b1);
    check("s3_arm_bin", freq_bin, 32'd0);
    gap(40);
    check("s3_no_valid", nvalid - n0, 32'd0);
    check("s3_idle", busy, 32'd0);
    gap(959);
    cyc(1'b1);
    check("s3_own_bin", freq_bin, 32'd100);

    // Scenario 4: 41 edges plus one detected in the tick cycle
    half = 0; man_sig = 1'b0;
    gap(40);
    cyc(1'b1);
    gap(40);
    for (int i = 0; i < 41; i++) begin
      man_sig = 1'b1; cyc(1'b0); cyc(1'b0);
      man_sig = 1'b0; cyc(1'b0); cyc(1'b0);
    end
    gap(4);
    man_sig = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    check("s4_bin", freq_bin, 32'd42);
    n0 = nvalid;
    gap(40);
    check("s4_nvalid", nvalid - n0, 32'd1);
    check("s4_bcd", cap_bcd, 32'h0000_0042);
    man_sig = 1'b0;
    gap(59);
    cyc(1'b1);
    check("s4_new_win", freq_bin, 32'd0);

    // Scenario 5: reset at T+10 of a conversion
    half = 5;
    gap(40);
    cyc(1'b1);
    gap(40);
    gap(959);
    cyc(1'b1);
    check("s5_pre_bin", freq_bin, 32'd100);
    n0 = nvalid;
    gap(9);
    check("s5_pre_busy", busy, 32'd1);
    rst = 1'b0;
    #1;
    check("s5_rst_bin",   freq_bin, 32'd0);
    check("s5_rst_bcd",   freq_bcd, 32'd0);
    check("s5_rst_ovf",   ovf,      32'd0);
    check("s5_rst_valid", valid,    32'd0);
    check("s5_rst_busy",  busy,     32'd0);
    gap(5);
    rst = 1'b1;
    gap(40);
    check("s5_no_valid", nvalid - n0, 32'd0);
    gap(100);
    cyc(1'b1);
    check("s5_arm_bin", freq_bin, 32'd0);
    n0 = nvalid;
    gap(40);
    check("s5_arm_novalid", nvalid - n0, 32'd0);
    gap(959);
    cyc(1'b1);
    check("s5_win_bin", freq_bin, 32'd100);

    // Scenario 6: second armed tick at T+5 aborts the first conversion
    half = 0; man_sig = 1'b0;
    gap(40);
    cyc(1'b1);
    gap(40);
    for (int i = 0; i < 7; i++) begin
      man_sig = 1'b1; cyc(1'b0); cyc(1'b0);
      man_sig = 1'b0; cyc(1'b0); cyc(1'b0);
    end
    gap(4);
    man_sig = 1'b1;
    n0 = nvalid;
    cyc(1'b1);
    check("s6_first_bin", freq_bin, 32'd7);
    man_sig = 1'b0; cyc(1'b0);
    man_sig = 1'b1; cyc(1'b0);
    man_sig = 1'b0; cyc(1'b0);
    cyc(1'b0);
    cyc(1'b1);
    check("s6_second_bin", freq_bin, 32'd2);
    gap(40);
    check("s6_one_valid", nvalid - n0, 32'd1);
    check("s6_latency", vat, 32'd28);
    check("s6_bcd", cap_bcd, 32'h0000_0002);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
